// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the 4-way round-robin packet arbiter.
// Holds the state encoding, default data width and the rotating pick function.
package rr_arbiter4_pkg;

    localparam int unsigned WORD = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First requester with valid set, scanning start, start+1, ... with 2-bit wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && valid[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 data multiplexer used as the shared output path of the arbiter.
module mux4 #(
    parameter int unsigned SIZE = 64
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [SIZE-1:0] c,
    input  logic [SIZE-1:0] d,
    input  logic [1:0]      sel,
    output logic [SIZE-1:0] out
);

    always_comb begin
        unique case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin packet arbiter: grants whole packets from 4 requesters onto one
// valid/ready output port, with a watchdog that releases a stalled owner.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned SIZE    = WORD,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req_valid,
    input  logic [3:0]      req_last,
    input  logic [SIZE-1:0] req_data_a,
    input  logic [SIZE-1:0] req_data_b,
    input  logic [SIZE-1:0] req_data_c,
    input  logic [SIZE-1:0] req_data_d,
    output logic [3:0]      req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_last,
    output logic [3:0]      grant,
    output logic [1:0]      sel,
    output logic            timeout_err
);

    localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    state_t         state;
    logic [1:0]     ptr;
    logic [WDW-1:0] wdog;

    logic       busy;
    logic       xfer;
    logic [1:0] owner_next;
    logic [1:0] idle_pick;
    logic [1:0] chain_pick;

    always_comb begin
        busy       = (state == BUSY);
        out_valid  = busy & req_valid[sel];
        out_last   = busy & req_last[sel];
        xfer       = out_valid & out_ready;
        req_ready  = grant & {4{xfer}};
        owner_next = sel + 2'd1;
        idle_pick  = rr_pick(req_valid, ptr);
        // Back-to-back pick starts just past the finishing owner, making it lowest priority.
        chain_pick = rr_pick(req_valid, owner_next);
    end

    mux4 #(.SIZE(SIZE)) u_mux4 (
        .a   (req_data_a),
        .b   (req_data_b),
        .c   (req_data_c),
        .d   (req_data_d),
        .sel (sel),
        .out (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            sel         <= '0;
            ptr         <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state <= BUSY;
                        sel   <= idle_pick;
                        grant <= 4'b0001 << idle_pick;
                        wdog  <= '0;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        wdog <= '0;
                        if (out_last) begin
                            ptr <= owner_next;
                            if (|req_valid) begin
                                sel   <= chain_pick;
                                grant <= 4'b0001 << chain_pick;
                            end else begin
                                state <= IDLE;
                                grant <= '0;
                            end
                        end
                    end else if (TIMEOUT > 0) begin
                        if (wdog == WDOG_LAST) begin
                            state       <= IDLE;
                            grant       <= '0;
                            ptr         <= owner_next;
                            wdog        <= '0;
                            timeout_err <= 1'b1;
                        end else if (wdog != '1) begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
